// File: rtl/cpu_seq_pkg.sv
// Shared opcode, field and state definitions for the instruction sequencer.
// SEQ_SINGLE_STEP_EN adds the PAUSE state used for single stepping.
package cpu_seq_pkg;

    localparam int OP_HI = 19;
    localparam int OP_LO = 18;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;
`endif

    // A hold length of zero still has to drive the word for one cycle.
    function automatic int cyc_fix(input int c);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer.
// Synchronous write, asynchronous read, no reset of contents.
module seq_prog_mem #(
    parameter int AW = 4,
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_instr_sequencer.sv
// Program sequencer driving simple_cpu one instruction at a time.
// SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state between instructions.
module cpu_instr_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int INSTR_WIDTH    = 20,
    parameter int PROG_ADDR_BITS = 4,
    parameter int ALU_CYCLES     = 3,
    parameter int LOAD_CYCLES    = 4,
    parameter int STORE_CYCLES   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_we,
    input  logic [PROG_ADDR_BITS-1:0] prog_addr,
    input  logic [INSTR_WIDTH-1:0]    prog_data,
    input  logic [PROG_ADDR_BITS:0]   prog_len,
    input  logic                      start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                      step,
`endif
    output logic [INSTR_WIDTH-1:0]    instruction,
    output logic [PROG_ADDR_BITS-1:0] pc,
    output logic                      issue,
    output logic                      busy,
    output logic                      done
);

    localparam int AW    = PROG_ADDR_BITS;
    localparam int CA    = cyc_fix(ALU_CYCLES);
    localparam int CL    = cyc_fix(LOAD_CYCLES);
    localparam int CS    = cyc_fix(STORE_CYCLES);
    localparam int CM1   = (CA > CL) ? CA : CL;
    localparam int CMAX  = (CM1 > CS) ? CM1 : CS;
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(2**AW);

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [AW-1:0]          pc_q, pc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [AW:0]            len_q, len_d;
    logic                   issue_q, issue_d;

    logic                   idle_like;
    logic                   mem_we;
    logic [AW-1:0]          rd_addr;
    logic [INSTR_WIDTH-1:0] rd_data;
    logic [INSTR_WIDTH-1:0] word;
    logic [AW:0]            plen_c;
    logic                   last;
    logic                   fetch;

    function automatic logic [CW-1:0] reload(input logic [1:0] op);
        case (op)
            OP_LOAD:  return CW'(CL - 1);
            OP_STORE: return CW'(CS - 1);
            default:  return CW'(CA - 1);
        endcase
    endfunction

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign mem_we    = prog_we && idle_like;
    assign rd_addr   = idle_like ? '0 : pc_q + AW'(1);
    assign plen_c    = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last      = ({1'b0, pc_q} == len_q - (AW+1)'(1));

    seq_prog_mem #(
        .AW(AW),
        .DW(INSTR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    // A write on the start edge must be visible to the first fetch.
    assign word = (mem_we && prog_addr == rd_addr) ? prog_data : rd_data;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        issue_d = 1'b0;
        fetch   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d   = plen_c;
                    pc_d    = '0;
                    instr_d = '0;
                    state_d = S_DONE;
                    fetch   = (plen_c != '0);
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (last) begin
                    instr_d = '0;
                    state_d = S_DONE;
                end else begin
`ifdef SEQ_SINGLE_STEP_EN
                    state_d = S_PAUSE;
`else
                    fetch = 1'b1;
`endif
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: fetch = step;
`endif
            default: ;
        endcase
        if (fetch) begin
            pc_d = rd_addr;
            if (word[OP_HI:OP_LO] == OP_HALT) begin
                instr_d = '0;
                state_d = S_DONE;
            end else begin
                instr_d = word;
                cnt_d   = reload(word[OP_HI:OP_LO]);
                issue_d = 1'b1;
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            issue_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            issue_q <= issue_d;
        end
    end

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign issue       = issue_q;
    assign done        = (state_q == S_DONE);
`ifdef SEQ_SINGLE_STEP_EN
    assign busy = (state_q == S_RUN) || (state_q == S_PAUSE);
`else
    assign busy = (state_q == S_RUN);
`endif

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Scoreboard bench for cpu_instr_sequencer against a program-level model.
// Built with SEQ_SINGLE_STEP_EN the bench holds step high.
module tb_cpu_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic [19:0] instruction;
    logic [3:0]  pc;
    logic        issue, busy, done;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step = 1'b1;
    localparam int PSTEP = 1;
`else
    localparam int PSTEP = 0;
`endif

    cpu_instr_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_len   (prog_len),
        .start      (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .instruction(instruction),
        .pc         (pc),
        .issue      (issue),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        int          pc;
        logic [19:0] ins;
        int          gap;
    } ev_t;

    ev_t         sbq[$];
    logic [19:0] mdl [16];
    int          tests = 0;
    int          fails = 0;

    function automatic int cyc(input logic [1:0] op);
        return (op == 2'b10) ? 4 : 3;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected issue/done events for one run of the model program.
    task automatic expect_run(input int plen);
        int len;
        int prev;
        ev_t e;
        len = (plen > 16) ? 16 : plen;
        prev = 0;
        if (len == 0) begin
            e = '{1'b1, 0, 20'h0, 0};
            sbq.push_back(e);
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (mdl[i][19:18] == 2'b00) begin
                e = '{1'b1, i, 20'h0, (i == 0) ? 0 : prev + PSTEP};
                sbq.push_back(e);
                return;
            end
            e = '{1'b0, i, mdl[i], (i == 0) ? 0 : prev + PSTEP};
            sbq.push_back(e);
            prev = cyc(mdl[i][19:18]);
        end
        e = '{1'b1, len - 1, 20'h0, prev};
        sbq.push_back(e);
    endtask

    task automatic write_word(input int a, input logic [19:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = d;
        mdl[a]    = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic start_run(input int plen, input bit wr0, input logic [19:0] w0);
        @(negedge clk);
        start    = 1'b1;
        prog_len = 5'(plen);
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = 4'd0;
            prog_data = w0;
            mdl[0]    = w0;
        end
        expect_run(plen);
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && done) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s timeout: queue=%0d done=%0b expected empty/1", name, sbq.size(), done);
        end
    endtask

    // Monitor: pops the scoreboard on every issue and on each entry into DONE.
    int          since = 0;
    logic        done_d = 1'b0;
    logic [19:0] cur = '0;

    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            since  = 0;
            done_d = 1'b0;
        end else begin
            since++;
            if (issue) begin
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_issue: got pc=%0d ins=%h expected none", pc, instruction);
                end else begin
                    e = sbq.pop_front();
                    chk("issue_kind", 0, e.is_done);
                    chk("issue_pc", pc, e.pc);
                    chk("issue_ins", instruction, e.ins);
                    if (e.gap != 0) chk("issue_gap", since, e.gap);
                end
                cur   = instruction;
                since = 0;
            end else if (busy) begin
                chk("hold_stable", instruction, cur);
            end
            if (done && !done_d) begin
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got pc=%0d expected none", pc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_kind", 1, e.is_done);
                    chk("done_pc", pc, e.pc);
                    if (e.gap != 0) chk("done_gap", since, e.gap);
                end
                since = 0;
            end
            if (done) chk("done_ins_zero", instruction, 0);
            done_d = done;
        end
    end

    initial begin
        logic [19:0] w;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ins", instruction, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", pc, 0);

        write_word(0, 20'h47000);
        write_word(1, 20'h53000);
        write_word(2, 20'h72001);
        start_run(3, 1'b0, 20'h0);
        wait_done("alu3");

        write_word(3, 20'hD80F0);
        write_word(4, 20'hB80F0);
        start_run(5, 1'b0, 20'h0);
        wait_done("store_load");

        // Start and writes while busy must not disturb the run.
        start_run(5, 1'b0, 20'h0);
        repeat (2) @(negedge clk);
        start     = 1'b1;
        prog_len  = 5'd1;
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = 20'h00000;
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        wait_done("busy_ignore");

        start_run(5, 1'b0, 20'h0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_ins", instruction, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_issue", issue, 0);

        start_run(0, 1'b0, 20'h0);
        wait_done("len0");

        write_word(1, 20'h00000);
        start_run(3, 1'b0, 20'h0);
        wait_done("early_halt");

        for (int r = 0; r < 25; r++) begin
            for (int i = 1; i < 16; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    w = 20'($urandom);
                    if ($urandom_range(0, 7) == 0) w[19:18] = 2'b00;
                    else if (w[19:18] == 2'b00) w[19:18] = 2'b01;
                    write_word(i, w);
                end
            end
            w = 20'($urandom);
            if (w[19:18] == 2'b00) w[19:18] = 2'b10;
            start_run(int'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), w);
            wait_done("random");
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
